// File: rtl/iec_sd_arbiter.sv
// Round-robin arbiter that merges per-drive SD sector requests onto one host SD channel.
// It carries one transfer at a time and returns the host ack to the granted drive.
module iec_sd_arbiter #(
    parameter int unsigned NDR     = 2,
    parameter logic [23:0] TIMEOUT = 24'd16000000
) (
    input  logic                  clk_sys,
    input  logic                  reset_n,
    input  logic [NDR-1:0][31:0]  sd_lba,
    input  logic [NDR-1:0][5:0]   sd_blk_cnt,
    input  logic [NDR-1:0]        sd_rd,
    input  logic [NDR-1:0]        sd_wr,
    output logic [NDR-1:0]        sd_ack,
    input  logic [NDR-1:0][7:0]   sd_buff_din,
    output logic [31:0]           host_lba,
    output logic [5:0]            host_blk_cnt,
    output logic                  host_rd,
    output logic                  host_wr,
    input  logic                  host_ack,
    output logic [7:0]            host_buff_din,
    output logic [1:0]            grant,
    output logic                  busy,
    output logic                  timeout_err
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StReq  = 2'd1;
    localparam logic [1:0] StXfer = 2'd2;
    localparam logic [1:0] StDone = 2'd3;

    localparam logic [1:0] LastDrv = 2'(NDR - 1);

    // Per-drive inputs padded to four slots so a 2-bit grant can index them for any NDR.
    logic [3:0][31:0] lba4;
    logic [3:0][5:0]  blk4;
    logic [3:0][7:0]  din4;
    logic [3:0]       rd4;
    logic [3:0]       pend4;

    for (genvar i = 0; i < 4; i++) begin : g_pad
        if (i < NDR) begin : g_used
            assign lba4[i]  = sd_lba[i];
            assign blk4[i]  = sd_blk_cnt[i];
            assign din4[i]  = sd_buff_din[i];
            assign rd4[i]   = sd_rd[i];
            assign pend4[i] = sd_rd[i] | sd_wr[i];
        end else begin : g_unused
            assign lba4[i]  = '0;
            assign blk4[i]  = '0;
            assign din4[i]  = '0;
            assign rd4[i]   = 1'b0;
            assign pend4[i] = 1'b0;
        end
    end

    logic [1:0]  state_q, state_d;
    logic [1:0]  grant_q, grant_d;
    logic [31:0] lba_q, lba_d;
    logic [5:0]  blk_q, blk_d;
    logic        rd_q, rd_d;
    logic        wr_q, wr_d;
    logic [3:0]  ack_q, ack_d;
    logic [23:0] cnt_q, cnt_d;
    logic        to_q, to_d;

    // Search grant+1, grant+2, ... with an explicit wrap at the last drive.
    logic [1:0] cand;
    logic [1:0] win;
    logic       found;

    always_comb begin
        cand  = grant_q;
        win   = grant_q;
        found = 1'b0;
        for (int k = 0; k < 4; k++) begin
            cand = (cand == LastDrv) ? 2'd0 : 2'(cand + 2'd1);
            if (!found && pend4[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    logic [3:0] grant_oh;
    assign grant_oh = 4'd1 << grant_q;

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        lba_d   = lba_q;
        blk_d   = blk_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        ack_d   = ack_q;
        cnt_d   = cnt_q;
        to_d    = 1'b0;
        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (found) begin
                    grant_d = win;
                    lba_d   = lba4[win];
                    blk_d   = blk4[win];
                    rd_d    = rd4[win];
                    wr_d    = ~rd4[win];
                    state_d = StReq;
                end
            end
            StReq: begin
                cnt_d = cnt_q + 24'd1;
                if (host_ack) begin
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    ack_d   = grant_oh;
                    state_d = StXfer;
                end else if ((TIMEOUT != 24'd0) && (cnt_q + 24'd1 == TIMEOUT)) begin
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    to_d    = 1'b1;
                    state_d = StDone;
                end else if (!pend4[grant_q]) begin
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    state_d = StDone;
                end
            end
            StXfer: begin
                if (!host_ack) begin
                    ack_d   = '0;
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            grant_q <= LastDrv;
            lba_q   <= '0;
            blk_q   <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            ack_q   <= '0;
            cnt_q   <= '0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            lba_q   <= lba_d;
            blk_q   <= blk_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            ack_q   <= ack_d;
            cnt_q   <= cnt_d;
            to_q    <= to_d;
        end
    end

    assign sd_ack        = ack_q[NDR-1:0];
    assign host_lba      = lba_q;
    assign host_blk_cnt  = blk_q;
    assign host_rd       = rd_q;
    assign host_wr       = wr_q;
    assign host_buff_din = din4[grant_q];
    assign grant         = grant_q;
    assign busy          = (state_q != StIdle);
    assign timeout_err   = to_q;

endmodule

// File: tb/tb_iec_sd_arbiter.sv
// Bench for iec_sd_arbiter (NDR=4, TIMEOUT=10); every host request is scored against a queue of
// grants predicted when the drive requests are raised.
module tb_iec_sd_arbiter;

    logic             clk_sys;
    logic             reset_n;
    logic [3:0][31:0] sd_lba;
    logic [3:0][5:0]  sd_blk_cnt;
    logic [3:0]       sd_rd;
    logic [3:0]       sd_wr;
    logic [3:0]       sd_ack;
    logic [3:0][7:0]  sd_buff_din;
    logic [31:0]      host_lba;
    logic [5:0]       host_blk_cnt;
    logic             host_rd;
    logic             host_wr;
    logic             host_ack;
    logic [7:0]       host_buff_din;
    logic [1:0]       grant;
    logic             busy;
    logic             timeout_err;

    iec_sd_arbiter #(
        .NDR     (4),
        .TIMEOUT (24'd10)
    ) u_dut (
        .clk_sys       (clk_sys),
        .reset_n       (reset_n),
        .sd_lba        (sd_lba),
        .sd_blk_cnt    (sd_blk_cnt),
        .sd_rd         (sd_rd),
        .sd_wr         (sd_wr),
        .sd_ack        (sd_ack),
        .sd_buff_din   (sd_buff_din),
        .host_lba      (host_lba),
        .host_blk_cnt  (host_blk_cnt),
        .host_rd       (host_rd),
        .host_wr       (host_wr),
        .host_ack      (host_ack),
        .host_buff_din (host_buff_din),
        .grant         (grant),
        .busy          (busy),
        .timeout_err   (timeout_err)
    );

    initial begin
        clk_sys = 1'b0;
        forever #5 clk_sys = ~clk_sys;
    end

    int n_cmp = 0;
    int n_err = 0;

    // Expected request: {grant[1:0], rd, wr, lba[31:0], blk[5:0]}
    logic [41:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [1:0] g, input logic rd, input logic wr,
                        input logic [31:0] lba, input logic [5:0] blk);
        exp_q.push_back({g, rd, wr, lba, blk});
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    // Score every rising host request against the oldest prediction.
    initial begin
        logic        prev;
        logic [41:0] e;
        prev = 1'b0;
        forever begin
            @(posedge clk_sys);
            #1;
            if ((host_rd | host_wr) && !prev) begin
                check("sb_has_entry", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("sb_grant", 64'(grant), 64'(e[41:40]));
                    check("sb_rd", 64'(host_rd), 64'(e[39]));
                    check("sb_wr", 64'(host_wr), 64'(e[38]));
                    check("sb_lba", 64'(host_lba), 64'(e[37:6]));
                    check("sb_blk", 64'(host_blk_cnt), 64'(e[5:0]));
                end
            end
            prev = host_rd | host_wr;
        end
    end

    task automatic wait_req();
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (host_rd | host_wr) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        check("req_seen", 64'(seen), 64'd1);
    endtask

    task automatic serve(input int wait_cyc, input int ack_cyc);
        wait_req();
        repeat (wait_cyc) tick();
        host_ack = 1'b1;
        repeat (ack_cyc) tick();
        host_ack = 1'b0;
    endtask

    initial begin
        int cnt;
        reset_n     = 1'b0;
        host_ack    = 1'b0;
        sd_rd       = '0;
        sd_wr       = '0;
        sd_lba      = '0;
        sd_blk_cnt  = '0;
        sd_buff_din = '0;
        sd_buff_din[3] = 8'h77;
        repeat (2) tick();
        check("rst_sd_ack", 64'(sd_ack), 64'd0);
        check("rst_host_rd", 64'(host_rd), 64'd0);
        check("rst_host_wr", 64'(host_wr), 64'd0);
        check("rst_lba", 64'(host_lba), 64'd0);
        check("rst_blk", 64'(host_blk_cnt), 64'd0);
        check("rst_grant", 64'(grant), 64'd3);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_to", 64'(timeout_err), 64'd0);
        check("rst_buff", 64'(host_buff_din), 64'h77);
        reset_n = 1'b1;
        tick();

        // Single read on drive 0 with a 1-clock request latency and a 5-cycle ack.
        sd_lba[0]     = 32'h123;
        sd_blk_cnt[0] = 6'd5;
        sd_rd[0]      = 1'b1;
        push(2'd0, 1'b1, 1'b0, 32'h123, 6'd5);
        tick();
        check("t1_host_rd", 64'(host_rd), 64'd1);
        check("t1_lba", 64'(host_lba), 64'h123);
        check("t1_busy", 64'(busy), 64'd1);
        check("t1_ack_pre", 64'(sd_ack), 64'd0);
        sd_lba[0] = 32'hDEAD;
        tick();
        tick();
        check("t1_lba_held", 64'(host_lba), 64'h123);
        host_ack = 1'b1;
        tick();
        check("t1_ack_rise", 64'(sd_ack), 64'd1);
        check("t1_rd_drop", 64'(host_rd), 64'd0);
        sd_rd[0] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t1_ack_hold", 64'(sd_ack), 64'd1);
        end
        host_ack = 1'b0;
        tick();
        check("t1_ack_fall", 64'(sd_ack), 64'd0);
        check("t1_busy_done", 64'(busy), 64'd1);
        tick();
        check("t1_busy_idle", 64'(busy), 64'd0);

        // Round-robin with all four drives reading: grants 0,1,2,3,0 after a fresh reset.
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sd_lba[i]     = 32'h1000 + 32'(i);
            sd_blk_cnt[i] = 6'(i + 1);
        end
        sd_lba[0] = 32'h1000;
        for (int i = 0; i < 5; i++) begin
            push(2'(i % 4), 1'b1, 1'b0, 32'h1000 + 32'(i % 4), 6'((i % 4) + 1));
        end
        sd_rd = 4'hF;
        for (int i = 0; i < 5; i++) serve(3, 2);
        sd_rd = 4'h0;
        tick();
        tick();

        // Read and write together on drive 1: read wins.
        sd_lba[1] = 32'h2222;
        sd_rd[1]  = 1'b1;
        sd_wr[1]  = 1'b1;
        push(2'd1, 1'b1, 1'b0, 32'h2222, 6'd2);
        serve(1, 2);
        sd_rd[1] = 1'b0;
        sd_wr[1] = 1'b0;
        tick();
        tick();

        // Write on drive 2: its data byte reaches the host.
        sd_buff_din[1] = 8'h3C;
        sd_buff_din[2] = 8'hA5;
        sd_lba[2]      = 32'h3333;
        sd_wr[2]       = 1'b1;
        push(2'd2, 1'b0, 1'b1, 32'h3333, 6'd3);
        wait_req();
        check("t3_buff_req", 64'(host_buff_din), 64'hA5);
        host_ack = 1'b1;
        tick();
        check("t3_ack", 64'(sd_ack), 64'h4);
        check("t3_buff_xfer", 64'(host_buff_din), 64'hA5);
        check("t3_wr_drop", 64'(host_wr), 64'd0);
        host_ack = 1'b0;
        sd_wr[2] = 1'b0;
        tick();
        tick();

        // Timeout on drive 3, then drive 0 is granted next.
        sd_lba[3] = 32'h4444;
        sd_lba[0] = 32'h5555;
        sd_rd[3]  = 1'b1;
        sd_rd[0]  = 1'b1;
        push(2'd3, 1'b1, 1'b0, 32'h4444, 6'd4);
        push(2'd0, 1'b1, 1'b0, 32'h5555, 6'd1);
        cnt = 0;
        tick();
        while (host_rd && cnt < 30) begin
            cnt++;
            tick();
        end
        check("t4_rd_cycles", 64'(cnt), 64'd10);
        check("t4_to_pulse", 64'(timeout_err), 64'd1);
        check("t4_no_ack", 64'(sd_ack), 64'd0);
        check("t4_busy_done", 64'(busy), 64'd1);
        sd_rd[3] = 1'b0;
        tick();
        check("t4_to_once", 64'(timeout_err), 64'd0);
        check("t4_idle", 64'(busy), 64'd0);
        serve(2, 2);
        sd_rd[0] = 1'b0;
        tick();
        tick();

        // Drive 3 withdraws its write during REQ.
        sd_lba[3] = 32'h6666;
        sd_wr[3]  = 1'b1;
        push(2'd3, 1'b0, 1'b1, 32'h6666, 6'd4);
        tick();
        check("t5_host_wr", 64'(host_wr), 64'd1);
        tick();
        sd_wr[3] = 1'b0;
        tick();
        check("t5_wr_drop", 64'(host_wr), 64'd0);
        check("t5_no_ack", 64'(sd_ack), 64'd0);
        check("t5_done", 64'(busy), 64'd1);
        tick();
        check("t5_idle", 64'(busy), 64'd0);

        // Asynchronous reset in the middle of a drive 1 transfer.
        sd_lba[1] = 32'h7777;
        sd_rd[1]  = 1'b1;
        push(2'd1, 1'b1, 1'b0, 32'h7777, 6'd2);
        wait_req();
        host_ack = 1'b1;
        tick();
        check("t6_ack_pre", 64'(sd_ack), 64'h2);
        #2;
        reset_n = 1'b0;
        #1;
        check("t6_rst_ack", 64'(sd_ack), 64'd0);
        check("t6_rst_rd", 64'(host_rd), 64'd0);
        check("t6_rst_grant", 64'(grant), 64'd3);
        check("t6_rst_busy", 64'(busy), 64'd0);
        check("t6_rst_lba", 64'(host_lba), 64'd0);
        host_ack  = 1'b0;
        sd_rd[1]  = 1'b0;
        sd_lba[0] = 32'h8888;
        sd_rd[0]  = 1'b1;
        push(2'd0, 1'b1, 1'b0, 32'h8888, 6'd1);
        #2;
        reset_n = 1'b1;
        serve(1, 2);
        sd_rd[0] = 1'b0;
        tick();
        tick();
        check("t6_idle", 64'(busy), 64'd0);
        check("sb_drained", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
